conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Sequencer for the K×K sliding-window datapath built from the line-buffer shift registers of the convolution front end. Accepts a raster-order pixel stream with valid/ready handshake, drives the shared shift-enable for all line buffers and window registers, and tracks row/column position. Flags each cycle in which a complete K×K window sits in the window registers. Applies downstream back-pressure so no window is overwritten before it is consumed.

## Interface
- IMG_W, 28, image width in pixels (≥ K)
- IMG_H, 28, image height in pixels (≥ K)
- K, 3, kernel size (≥ 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a frame; honoured only in IDLE
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle pulse when a frame completes
- pix_valid  in  1  upstream pixel present
- pix_ready  out  1  controller accepts pixel this cycle
- sr_ce  out  1  shift-enable to all line buffers and window registers (combinational)
- win_valid  out  1  complete window present in window registers
- win_ready  in  1  downstream consumes window
- win_row  out  clog2(IMG_H)  top-left row of presented window
- win_col  out  clog2(IMG_W)  top-left column of presented window

## Operation
- States: IDLE, STREAM, DRAIN. Reset → IDLE.
- IDLE: `start` → STREAM; row and col counters cleared to 0.
- Accept = `pix_valid & pix_ready`; `sr_ce` = accept exactly, so line buffers shift on the same edge the pixel is taken.
- `pix_ready` = (state==STREAM) & ~(win_valid & ~win_ready). Ready is therefore still asserted in a cycle where a pending window is being consumed.
- Counters (row, col) hold the position of the next pixel. Each accept increments col. At col==IMG_W-1, col wraps to 0 and row increments.
- Window generation: on accepting pixel (r,c) with r ≥ K-1 and c ≥ K-1, `win_valid` sets on the next edge, with win_row=r-K+1 and win_col=c-K+1.
- `win_valid` stays high and win_row/win_col stay stable until a cycle with `win_ready` high.
- If a window is consumed and a new window-producing pixel is accepted in the same cycle, `win_valid` stays 1 and the coordinates update.
- Accepting the last pixel (IMG_H-1, IMG_W-1) → DRAIN. `pix_ready`=0 in DRAIN.
- DRAIN: once `win_valid` is clear or consumed (`win_ready` high), the next edge returns to IDLE and pulses `done` for one cycle.
- Windows per frame: (IMG_H-K+1)·(IMG_W-K+1). No windows from row/column wrap positions (c < K-1).
- `start` in STREAM/DRAIN ignored. `win_ready` with no `win_valid` ignored.

## Timing
- Reset values: busy=0, done=0, pix_ready=0, win_valid=0, win_row=0, win_col=0; sr_ce=0 since pix_ready=0.
- start→pix_ready: 1 cycle (STREAM entered on the edge after start).
- Window latency: 1 cycle from accepting the completing pixel to `win_valid`.
- Throughput: 1 pixel/cycle and 1 window/cycle when win_ready is held high.
- done: asserted 1 cycle after the final window handshake. If the final window was already consumed, done is asserted 1 cycle after entering DRAIN.
- rst mid-frame: immediate return to IDLE with all outputs at reset values. Line buffers share rst, so no stale window survives.

## Configuration
- CONV_WIN_STRIDE2_EN defined: adds input `cfg_stride2` (1 bit), sampled on start in IDLE. When sampled high, a window is produced only where (r-K+1) and (c-K+1) are both even. Windows per frame become ceil((IMG_H-K+1)/2)·ceil((IMG_W-K+1)/2). Pixel acceptance and sr_ce are unchanged.
- Undefined: port absent; stride fixed at 1.

## Test plan
- IMG_W=5, IMG_H=5, K=3, pix_valid and win_ready held high → 25 accepts in 25 cycles, 9 windows at (0,0)…(2,2) in raster order, each 1 cycle after the pixel at (r+2,c+2); done 1 cycle after window (2,2).
- Same config, win_ready low for 4 cycles when window (1,1) appears → pix_ready=0 and sr_ce=0 for those 4 cycles; win_row/win_col hold 1/1; stream resumes with no loss; exactly 9 windows.
- pix_valid toggling 1,0,1,0 → sr_ce pulses only on accepts; counters advance only on accepts; windows identical to the first scenario.
- rst asserted after 12 accepts → all outputs 0 asynchronously; a new start then yields a full 9-window frame from (0,0).
- start asserted during STREAM → ignored; counters undisturbed.
- CONV_WIN_STRIDE2_EN, cfg_stride2=1, IMG 5×5, K=3 → 4 windows at (0,0),(0,2),(2,0),(2,2); 25 accepts.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// Sliding-window sequencer: drives the shared line-buffer shift-enable, tracks raster
// position and presents K x K windows with back-pressure. Optional: CONV_WIN_STRIDE2_EN.
module conv_window_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic                       sr_ce,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col
`ifdef CONV_WIN_STRIDE2_EN
    ,
    input  logic                       cfg_stride2
`endif
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic               r_win_valid;
    logic [ROW_W-1:0]   r_win_row;
    logic [COL_W-1:0]   r_win_col;
    logic               r_done;

    logic               w_pix_ready;
    logic               w_accept;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_stride_ok;
    logic               w_win_gen;

    // Stall only when a window is pending and not being taken this cycle.
    assign w_pix_ready = (r_state == S_STREAM) && !(r_win_valid && !win_ready);
    assign w_accept    = pix_valid && w_pix_ready;
    assign w_last_col  = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row  = (r_row == ROW_W'(IMG_H - 1));

`ifdef CONV_WIN_STRIDE2_EN
    localparam logic KM1_ODD = ((K - 1) % 2) == 1;
    logic r_stride2;

    // Parity of (pos - K + 1) equals parity of pos xor parity of (K - 1).
    assign w_stride_ok = !r_stride2 || ((r_row[0] == KM1_ODD) && (r_col[0] == KM1_ODD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stride2 <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_stride2 <= cfg_stride2;
    end
`else
    assign w_stride_ok = 1'b1;
`endif

    assign w_win_gen = w_accept && (r_row >= ROW_W'(K - 1)) && (r_col >= COL_W'(K - 1))
                       && w_stride_ok;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_STREAM;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row)
                                r_state <= S_DRAIN;
                            else
                                r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_win_valid || win_ready) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A new window overrides a same-cycle consume; otherwise a consume clears.
            if (w_win_gen) begin
                r_win_valid <= 1'b1;
                r_win_row   <= r_row - ROW_W'(K - 1);
                r_win_col   <= r_col - COL_W'(K - 1);
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign pix_ready = w_pix_ready;
    assign sr_ce     = w_accept;
    assign win_valid = r_win_valid;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl on a 5x5 image with a 3x3 kernel: the monitor derives
// expected windows from the raster index of each accepted pixel.
module tb_conv_window_ctrl;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int KK   = 3;
    localparam int NWIN = (H - KK + 1) * (W - KK + 1);
    localparam int NPIX = W * H;

    typedef struct packed {
        int r;
        int c;
    } win_t;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     pix_valid;
    logic                     pix_ready;
    logic                     sr_ce;
    logic                     win_valid;
    logic                     win_ready;
    logic [$clog2(H)-1:0]     win_row;
    logic [$clog2(W)-1:0]     win_col;

    int   vectors;
    int   miscompares;
    int   n_acc;
    int   n_win;
    bit   exp_done;
    win_t q_exp[$];

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .sr_ce     (sr_ce),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: reference model works from the raster index of each accepted pixel.
    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            n_acc    = 0;
            n_win    = 0;
            exp_done = 1'b0;
        end else begin
            check("done", done, exp_done);
            exp_done = 1'b0;
            check("sr_ce_is_accept", sr_ce, pix_valid & pix_ready);
            if (win_valid && !win_ready)
                check("backpressure_ready", pix_ready, 0);
            if (q_exp.size() > 0)
                check("win_valid", win_valid, 1);
            if (win_valid) begin
                check("win_pending", q_exp.size(), 1);
                if (q_exp.size() > 0) begin
                    check("win_row", win_row, q_exp[0].r);
                    check("win_col", win_col, q_exp[0].c);
                    if (win_ready) begin
                        void'(q_exp.pop_front());
                        n_win++;
                        if (n_win == NWIN)
                            exp_done = 1'b1;
                    end
                end
            end
            if (sr_ce) begin
                int r;
                int c;
                r = n_acc / W;
                c = n_acc % W;
                if (r >= KK - 1 && c >= KK - 1)
                    q_exp.push_back('{r: r - KK + 1, c: c - KK + 1});
                n_acc++;
            end
            if (start && !busy) begin
                n_acc = 0;
                n_win = 0;
            end
        end
    end

    // vmode: 0 always valid, 1 toggle 1,0,..., 2 random
    // rmode: 0 always ready, 1 random, 2 four-cycle stall on window (1,1)
    task automatic run_frame(input int vmode, input int rmode, input bit inj_start,
                             input int stop_acc);
        int cyc;
        int stall;
        bit seen;
        bit stalled;
        @(posedge clk);
        #1;
        start     = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_to_ready", pix_ready, 1);
        check("busy_in_stream", busy, 1);
        cyc     = 0;
        stall   = 0;
        seen    = 1'b0;
        stalled = 1'b0;
        while (!seen && cyc < 400) begin
            if (stop_acc > 0 && n_acc >= stop_acc)
                break;
            case (vmode)
                0:       pix_valid = 1'b1;
                1:       pix_valid = (cyc % 2 == 0);
                default: pix_valid = 1'($urandom_range(0, 1));
            endcase
            if (rmode == 2 && !stalled && win_valid && win_row == 1 && win_col == 1) begin
                stall   = 4;
                stalled = 1'b1;
            end
            if (stall > 0) begin
                win_ready = 1'b0;
                stall--;
            end else if (rmode == 1) begin
                win_ready = ($urandom_range(0, 3) != 0);
            end else begin
                win_ready = 1'b1;
            end
            start = inj_start && (cyc == 7);
            @(posedge clk);
            #1;
            cyc++;
            if (done)
                seen = 1'b1;
        end
        start = 1'b0;
        if (stop_acc > 0)
            return;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        check("done_seen", seen, 1);
        if (vmode == 0 && rmode == 0)
            check("frame_cycles", cyc, NPIX + 1);
        if (rmode == 2)
            check("stall_applied", stalled, 1);
        @(negedge clk);
        #1;
        check("window_count", n_win, NWIN);
        check("accept_count", n_acc, NPIX);
        check("queue_empty", q_exp.size(), 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_sr_ce"}, sr_ce, 0);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_win_row"}, win_row, 0);
        check({tag, "_win_col"}, win_col, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        pix_valid   = 1'b1;
        win_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        pix_valid = 1'b0;
        rst       = 1'b0;

        run_frame(0, 0, 1'b0, 0);
        run_frame(0, 2, 1'b0, 0);
        run_frame(1, 0, 1'b0, 0);
        run_frame(0, 0, 1'b1, 0);
        run_frame(2, 1, 1'b1, 0);

        run_frame(0, 0, 1'b0, 12);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        @(negedge clk);
        #1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        run_frame(0, 0, 1'b0, 0);

        for (int i = 0; i < 3; i++)
            run_frame(2, 1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
